// File: rtl/dfp_arb_pkg.sv
// Shared types and constants for the dfp memory-port arbiter.
// Optional feature macro: DFP_ARB_ROUND_ROBIN_EN (see dfp_arbiter.sv).
package dfp_arb_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 32;
  localparam int LINE_W_DEF  = 256;
  localparam int OWNER_W     = $clog2(NUM_REQ_DEF);

  typedef logic [LINE_W_DEF-1:0] line_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dfp_arbiter_pick.sv
// Combinational first-set-bit search over a request vector, starting at
// start_idx and wrapping around. Tie start_idx to 0 for fixed priority.
module arb_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start_idx,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Walk the vector from start_idx; the first set bit found wins.
  always_comb begin
    int j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start_idx) + k) % N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/dfp_arbiter.sv
// Arbiter sharing one cacheline memory port (dfp_*) between NUM_REQ caches.
// A winner is picked in IDLE, registered as owner, and owns the port in BUSY
// until dfp_resp; req_resp pulses only to the owner in the dfp_resp cycle.
//
// Handshake: a requester raises req_read or req_write with addr/wdata and
// holds them stable up to and including the cycle its req_resp is high; the
// arbiter never preempts and ignores dfp_resp when no grant is outstanding.
//
// Macro DFP_ARB_ROUND_ROBIN_EN: when defined, the search starts at rr_ptr,
// which advances to owner+1 on every completion; when undefined, fixed
// priority (index 0 highest) and no rr_ptr.
module dfp_arbiter
  import dfp_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
  output logic [NUM_REQ*LINE_W-1:0] req_rdata,
  output logic [NUM_REQ-1:0]        req_resp,
  output logic [ADDR_W-1:0]         dfp_addr,
  output logic                      dfp_read,
  output logic                      dfp_write,
  output logic [LINE_W-1:0]         dfp_wdata,
  input  logic [LINE_W-1:0]         dfp_rdata,
  input  logic                      dfp_resp,
  output arb_state_t                dbg_state
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] pick_start;
  logic [OW-1:0] pick_idx;
  logic          pick_valid;
  logic [NUM_REQ-1:0] req_any;

  assign req_any   = req_read | req_write;
  assign dbg_state = state_q;

`ifdef DFP_ARB_ROUND_ROBIN_EN
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  assign pick_start = rr_ptr_q;
`else
  assign pick_start = '0;
`endif

  arb_pick #(
    .N (NUM_REQ),
    .W (OW)
  ) u_pick (
    .req       (req_any),
    .start_idx (pick_start),
    .idx       (pick_idx),
    .valid     (pick_valid)
  );

  // State, owner and round-robin pointer registers; reset acts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
`ifdef DFP_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
`ifdef DFP_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Next-state logic and owner-selected output muxing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
`ifdef DFP_ARB_ROUND_ROBIN_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    req_resp  = '0;
    // Address/data follow the owner always; they only matter while BUSY.
    dfp_addr  = req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
    dfp_wdata = req_wdata[int'(owner_q)*LINE_W +: LINE_W];
    req_rdata = {NUM_REQ{dfp_rdata}};
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dfp_read  = req_read[owner_q];
        dfp_write = req_write[owner_q];
        if (dfp_resp) begin
          req_resp[owner_q] = 1'b1;
          state_d           = IDLE;
`ifdef DFP_ARB_ROUND_ROBIN_EN
          rr_ptr_d = OW'((int'(owner_q) + 1) % NUM_REQ);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Illegal requester behaviour and output sanity (simulation only).
  a_owner_holds: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY) |-> req_any[owner_q]);
  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
    ((req_read & req_write) == '0));
  a_resp_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_resp));

endmodule
